// File: rtl/fifo_rd_fwft.sv
// Read-side FWFT output stage of the async FIFO (rclk domain).
// Turns rempty/rinc pops with 1-cycle memory latency into a valid/ready stream.
module fifo_rd_fwft #(
  parameter int DATASIZE = 8
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rempty,
  output logic                rinc,
  input  logic [DATASIZE-1:0] rdata,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [1:0]          level
);

  logic [1:0]          cnt;
  logic [1:0]          cnt_nx;
  logic                inflight;
  logic [1:0]          head;
  logic [1:0]          tail;
  logic [DATASIZE-1:0] mem [3];
  logic [2:0]          occ;
  logic                pop;
  logic                wr;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for the in-flight word so it can always land.
  assign occ  = {1'b0, cnt} + {2'b0, inflight};
  assign rinc = !rrst && !rempty && (occ < 3'd3);

  assign pop = dout_valid & dout_ready;
  assign wr  = inflight;

  always_comb begin
    cnt_nx = cnt;
    unique case ({wr, pop})
      2'b10:   cnt_nx = cnt + 2'd1;
      2'b01:   cnt_nx = cnt - 2'd1;
      default: cnt_nx = cnt;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt        <= 2'd0;
      inflight   <= 1'b0;
      head       <= 2'd0;
      tail       <= 2'd0;
      dout_valid <= 1'b0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      inflight   <= rinc;
      cnt        <= cnt_nx;
      dout_valid <= (cnt_nx != 2'd0);
      if (wr) begin
        mem[tail] <= rdata;
        tail      <= wrap_inc(tail);
      end
      if (pop) head <= wrap_inc(head);
    end
  end

  assign dout  = mem[head];
  assign level = cnt;

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Randomized bench for fifo_rd_fwft against a queue-based stream model.
// Emulates the read-pointer block and 1-cycle-latency memory.
module tb_fifo_rd_fwft;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       rempty;
  logic       rinc;
  logic [7:0] rdata;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [1:0] level;

  fifo_rd_fwft #(.DATASIZE(8)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rinc(rinc),
    .rdata(rdata), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .level(level)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  logic [7:0] src [1024];
  int avail  = 0;
  int rd_idx = 0;
  int out_idx = 0;
  logic [7:0] q [$];
  bit   mif = 0;
  int   pend_idx = 0;
  int   nrinc = 0;
  int   run = 0;
  int   max_run = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit blk, input bit rdy);
    bit er;
    bit ev;
    @(negedge rclk);
    rrst       = rst;
    dout_ready = rdy;
    rempty     = blk || (rd_idx >= avail);
    rdata      = mif ? src[pend_idx] : 8'($urandom);
    #1;
    er = !rst && !rempty && (q.size() + int'(mif) < 3);
    ev = (q.size() != 0);
    chk("rinc", 32'(rinc), 32'(er));
    chk("valid", 32'(dout_valid), 32'(ev));
    chk("level", 32'(level), 32'(q.size()));
    chk("udf", 32'(dout_valid && level == 2'd0), 0);
    chk("ovf", 32'(mif && level == 2'd3), 0);
    if (ev) chk("dout", 32'(dout), 32'(q[0]));
    if (ev && rdy && !rst) begin
      chk("order", 32'(dout), 32'(src[out_idx]));
      out_idx++;
    end
    if (er) begin
      nrinc++;
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    @(posedge rclk);
    if (rst) begin
      q.delete();
      mif    = 0;
      rd_idx = avail;
      out_idx = avail;
    end else begin
      if (ev && rdy) void'(q.pop_front());
      if (mif) q.push_back(src[pend_idx]);
      mif = er;
      if (er) begin
        pend_idx = rd_idx;
        rd_idx++;
      end
    end
  endtask

  task automatic load(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      src[avail + i] = rnd ? 8'($urandom) : 8'(i);
    avail += n;
  endtask

  initial begin
    int n0;
    int o0;
    int guard;
    rrst = 1'b1; rempty = 1'b1; dout_ready = 1'b0; rdata = 8'h00;

    // reset then idle
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_lvl", 32'(level), 0);

    // single word with long hold
    src[avail] = 8'hA5;
    avail++;
    n0 = nrinc;
    for (int i = 0; i < 7; i++) cyc(0, 0, 0);
    chk("single_rinc", 32'(nrinc - n0), 1);
    chk("single_dout", 32'(dout), 32'hA5);
    chk("single_lvl", 32'(level), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("single_empty", 32'(dout_valid), 0);

    // streaming
    load(16, 0);
    n0 = nrinc; o0 = out_idx; max_run = 0; run = 0;
    for (int i = 0; i < 21; i++) cyc(0, 0, 1);
    chk("stream_rinc", 32'(nrinc - n0), 16);
    chk("stream_run", 32'(max_run), 16);
    chk("stream_out", 32'(out_idx - o0), 16);

    // full backpressure
    load(8, 1);
    n0 = nrinc; o0 = out_idx;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    chk("bp_rinc", 32'(nrinc - n0), 3);
    chk("bp_lvl", 32'(level), 3);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1);
    chk("bp_rinc2", 32'(nrinc - n0), 8);
    chk("bp_out", 32'(out_idx - o0), 8);

    // random rempty / ready
    load(200, 1);
    o0 = out_idx; guard = 0;
    while (out_idx - o0 < 200 && guard < 4000) begin
      cyc(0, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6));
      guard++;
    end
    chk("rand_done", 32'(out_idx - o0), 200);

    // reset mid-stream at level=2 with a word in flight
    load(10, 1);
    guard = 0;
    while (!(q.size() == 2 && mif) && guard < 20) begin
      cyc(0, 0, 0);
      guard++;
    end
    chk("mid_setup", 32'(q.size() == 2 && mif), 1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("mid_valid", 32'(dout_valid), 0);
    chk("mid_lvl", 32'(level), 0);
    chk("mid_rinc", 32'(rinc), 0);
    src[avail] = 8'h3C;
    avail++;
    load(5, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("mid_first", 32'(dout), 32'h3C);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    chk("mid_drain", 32'(out_idx), 32'(avail));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
